pipeline_stall_controller: RTL and testbench

//  Sequences the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_stall_controller_pkg.sv | 38 +++
 rtl/pipeline_stall_controller_if.sv | 60 ++++++
 rtl/pipeline_stall_controller_mem_wait_counter.sv | 44 ++++
 rtl/pipeline_stall_controller.sv | 142 ++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : pipeline_ctrl_pkg
//  Purpose   : Shared state encoding, widths and helper functions for the
//              pipeline stall controller.
//  Revision  : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam int REG_ADDR_W = 3;   // 8 general purpose registers
  localparam int WAIT_CNT_W = 4;   // memory wait down-counter width
  localparam int PERF_CNT_W = 16;  // performance counter width

  localparam logic [PERF_CNT_W-1:0] PERF_CNT_MAX = '1;

  // Value loaded into the wait counter on MEM_WAIT entry. The entry cycle
  // and the exit cycle both belong to the access, so two cycles are excluded.
  function automatic logic [WAIT_CNT_W-1:0] wait_load_value(input int latency);
    if (latency < 2) return '0;
    return WAIT_CNT_W'(latency - 2);
  endfunction

  // Saturating increment used by the performance counters
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v,
                                                     input logic en);
    if (en && (v != PERF_CNT_MAX)) return v + PERF_CNT_W'(1);
    return v;
  endfunction

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_stall_controller_if.sv
`default_nettype none
// ============================================================================
//  Interface : pipeline_stall_controller_if
//  Purpose   : Hazard inputs from the datapath and the register enable /
//              bubble strobes returned by the stall controller.
//  Revision  : 1.0 - initial release
// ============================================================================
interface pipeline_stall_controller_if #(
  parameter int REG_ADDR_W = 3
);
  // Hazard information from the datapath
  logic                  memRead_EX;
  logic                  regWrite_EX;
  logic [REG_ADDR_W-1:0] rd_EX;
  logic [REG_ADDR_W-1:0] rs_ID;
  logic [REG_ADDR_W-1:0] rd_ID;
  logic                  useRs_ID;
  logic                  useRd_ID;
  logic                  memAccess_MEM;
  logic                  branchTaken_MEM;
  logic                  halt_WB;

  // Pipeline register control
  logic                  changeEnable_PC;
  logic                  changeEnable_IFID;
  logic                  changeEnable_IDEX;
  logic                  changeEnable_EXMEM;
  logic                  changeEnable_MEMWB;
  logic                  flush_IFID;
  logic                  flush_IDEX;
  logic                  flush_EXMEM;
  logic                  halted;

  // Performance counters
  logic [15:0]           stallCount;
  logic [15:0]           flushCount;
  logic [15:0]           memWaitCount;

  // Datapath side: drives hazard info, consumes enables
  modport master (
    output memRead_EX, regWrite_EX, rd_EX, rs_ID, rd_ID, useRs_ID, useRd_ID,
           memAccess_MEM, branchTaken_MEM, halt_WB,
    input  changeEnable_PC, changeEnable_IFID, changeEnable_IDEX,
           changeEnable_EXMEM, changeEnable_MEMWB,
           flush_IFID, flush_IDEX, flush_EXMEM, halted,
           stallCount, flushCount, memWaitCount
  );

  // Controller side
  modport slave (
    input  memRead_EX, regWrite_EX, rd_EX, rs_ID, rd_ID, useRs_ID, useRd_ID,
           memAccess_MEM, branchTaken_MEM, halt_WB,
    output changeEnable_PC, changeEnable_IFID, changeEnable_IDEX,
           changeEnable_EXMEM, changeEnable_MEMWB,
           flush_IFID, flush_IDEX, flush_EXMEM, halted,
           stallCount, flushCount, memWaitCount
  );

endinterface : pipeline_stall_controller_if
`default_nettype wire

// File: rtl/pipeline_stall_controller_mem_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module    : mem_wait_counter
//  Purpose   : Down-counter timing a multi-cycle memory access. Loads on
//              MEM_WAIT entry, decrements while waiting, flags zero.
//  Revision  : 1.0 - initial release
// ============================================================================
module mem_wait_counter
  import pipeline_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_value,
  input  logic                  dec,
  output logic                  zero
);

  logic [WAIT_CNT_W-1:0] count_q;
  logic [WAIT_CNT_W-1:0] count_d;

  // Load has priority; decrement stops at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WAIT_CNT_W'(1);
    end
  end

  // Counter register, cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule : mem_wait_counter
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module    : pipeline_stall_controller
//  Purpose   : Drives load enables and bubble strobes of the 5-stage pipeline
//              registers: load-use stalls, taken-branch flushes, multi-cycle
//              memory waits and HLT freeze.
//  Options   : STALL_PERF_CNT_EN - enables the saturating stall / flush /
//              memory-wait performance counters (tied to zero otherwise).
//  Revision  : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller #(
  parameter int REG_ADDR_W  = pipeline_ctrl_pkg::REG_ADDR_W,
  parameter int MEM_LATENCY = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  pipeline_stall_controller_if.slave    bus
);
  import pipeline_ctrl_pkg::*;

  localparam bit                    WAIT_EN   = (MEM_LATENCY > 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = wait_load_value(MEM_LATENCY);

  state_t                state_q;
  state_t                state_d;
  logic [REG_ADDR_W-1:0] rd_ex;
  logic [REG_ADDR_W-1:0] rs_id;
  logic [REG_ADDR_W-1:0] rd_id;
  logic                  load_use_hazard;
  logic                  wait_zero;
  logic                  halt_state;
  logic                  run_decode;
  logic                  wait_entry;
  logic                  wait_frozen;
  logic                  freeze_all;
  logic                  branch_flush;
  logic                  load_use_stall;

  assign rd_ex = bus.rd_EX;
  assign rs_id = bus.rs_ID;
  assign rd_id = bus.rd_ID;

  // Load in EX whose destination is a register the ID instruction reads
  always_comb begin
    load_use_hazard = bus.memRead_EX && bus.regWrite_EX &&
                      ((bus.useRs_ID && (rs_id == rd_ex)) ||
                       (bus.useRd_ID && (rd_id == rd_ex)));
  end

  // Per-cycle action, highest priority first: HALT, memory wait, branch, stall.
  // The final MEM_WAIT cycle (counter at zero) decodes like RUN, except that the
  // still-present memAccess_MEM belongs to the completing access and is ignored.
  always_comb begin
    halt_state     = (state_q == HALT);
    run_decode     = (state_q == RUN) || ((state_q == MEM_WAIT) && wait_zero);
    wait_entry     = WAIT_EN && (state_q == RUN) && bus.memAccess_MEM;
    wait_frozen    = wait_entry || ((state_q == MEM_WAIT) && !wait_zero);
    freeze_all     = halt_state || wait_frozen;
    branch_flush   = run_decode && !wait_entry && bus.branchTaken_MEM;
    load_use_stall = run_decode && !wait_entry && !bus.branchTaken_MEM &&
                     load_use_hazard;
  end

  // Next-state selection; HALT is sticky until reset
  always_comb begin
    state_d = RUN;
    if (bus.halt_WB || halt_state) begin
      state_d = HALT;
    end else if (wait_entry) begin
      state_d = MEM_WAIT;
    end else if ((state_q == MEM_WAIT) && !wait_zero) begin
      state_d = MEM_WAIT;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  mem_wait_counter u_mem_wait_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (wait_entry),
    .load_value (WAIT_LOAD),
    .dec        (state_q == MEM_WAIT),
    .zero       (wait_zero)
  );

  assign bus.changeEnable_PC    = !freeze_all && !load_use_stall;
  assign bus.changeEnable_IFID  = !freeze_all && !load_use_stall;
  assign bus.changeEnable_IDEX  = !freeze_all;
  assign bus.changeEnable_EXMEM = !freeze_all;
  assign bus.changeEnable_MEMWB = !freeze_all;
  assign bus.flush_IFID         = branch_flush;
  assign bus.flush_IDEX         = branch_flush || load_use_stall;
  assign bus.flush_EXMEM        = branch_flush;
  assign bus.halted             = halt_state;

`ifdef STALL_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_count_q;
  logic [PERF_CNT_W-1:0] stall_count_d;
  logic [PERF_CNT_W-1:0] flush_count_q;
  logic [PERF_CNT_W-1:0] flush_count_d;
  logic [PERF_CNT_W-1:0] mem_wait_count_q;
  logic [PERF_CNT_W-1:0] mem_wait_count_d;

  // Saturating event counts; HALT cycles are not memory-wait cycles
  always_comb begin
    stall_count_d    = sat_inc(stall_count_q, load_use_stall);
    flush_count_d    = sat_inc(flush_count_q, branch_flush);
    mem_wait_count_d = sat_inc(mem_wait_count_q, wait_frozen);
  end

  // Performance counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_q    <= '0;
      flush_count_q    <= '0;
      mem_wait_count_q <= '0;
    end else begin
      stall_count_q    <= stall_count_d;
      flush_count_q    <= flush_count_d;
      mem_wait_count_q <= mem_wait_count_d;
    end
  end

  assign bus.stallCount   = stall_count_q;
  assign bus.flushCount   = flush_count_q;
  assign bus.memWaitCount = mem_wait_count_q;
`else
  assign bus.stallCount   = 16'h0000;
  assign bus.flushCount   = 16'h0000;
  assign bus.memWaitCount = 16'h0000;
`endif

endmodule : pipeline_stall_controller
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module    : tb_pipeline_stall_controller
//  Purpose   : Self-checking bench for pipeline_stall_controller with a
//              three-cycle memory latency.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

  localparam int LAT = 3;
`ifdef STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Observation vector {en PC,IFID,IDEX,EXMEM,MEMWB, flush IFID,IDEX,EXMEM, halted}
  localparam logic [8:0] O_IDLE   = 9'b11111_000_0;
  localparam logic [8:0] O_LOAD   = 9'b00111_010_0;
  localparam logic [8:0] O_BRANCH = 9'b11111_111_0;
  localparam logic [8:0] O_FROZEN = 9'b00000_000_0;
  localparam logic [8:0] O_HALTED = 9'b00000_000_1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  pipeline_stall_controller_if #(.REG_ADDR_W(3)) bus ();

  pipeline_stall_controller #(.REG_ADDR_W(3), .MEM_LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [8:0] obs();
    return {bus.changeEnable_PC, bus.changeEnable_IFID, bus.changeEnable_IDEX,
            bus.changeEnable_EXMEM, bus.changeEnable_MEMWB,
            bus.flush_IFID, bus.flush_IDEX, bus.flush_EXMEM, bus.halted};
  endfunction

  function automatic logic [47:0] cnts();
    return {bus.stallCount, bus.flushCount, bus.memWaitCount};
  endfunction

  function automatic logic [47:0] exp_cnts(input int s, input int f, input int m);
    if (!PERF) return 48'h0;
    return {16'(s), 16'(f), 16'(m)};
  endfunction

  task automatic set_idle();
    bus.memRead_EX = 0; bus.regWrite_EX = 0; bus.rd_EX = 0; bus.rs_ID = 0;
    bus.rd_ID = 0; bus.useRs_ID = 0; bus.useRd_ID = 0; bus.memAccess_MEM = 0;
    bus.branchTaken_MEM = 0; bus.halt_WB = 0;
  endtask

  task automatic set_hazard(input logic [2:0] r);
    bus.memRead_EX = 1; bus.regWrite_EX = 1; bus.rd_EX = r;
    bus.rs_ID = r; bus.useRs_ID = 1; bus.rd_ID = r + 3'd1; bus.useRd_ID = 1;
  endtask

  // Leaves the bench at a negedge with reset released and the DUT in RUN
  task automatic do_reset();
    @(negedge clock); reset = 1; set_idle();
    @(negedge clock); reset = 0;
  endtask

  task automatic test_reset();
    do_reset(); set_idle(); #2;
    n_checks++;
    if (obs() !== O_IDLE) begin n_fail++; $display("FAIL reset_outputs got %b want %b", obs(), O_IDLE); end
    n_checks++;
    if (cnts() !== 48'h0) begin n_fail++; $display("FAIL reset_counters got %h want 0", cnts()); end
  endtask

  task automatic test_load_use();
    do_reset(); set_hazard(3'd3); bus.rd_ID = 3'd5; #2;
    n_checks++;
    if (obs() !== O_LOAD) begin n_fail++; $display("FAIL load_use_rs got %b want %b", obs(), O_LOAD); end
    @(negedge clock); set_idle(); #2;
    n_checks++;
    if (obs() !== O_IDLE) begin n_fail++; $display("FAIL load_use_after got %b want %b", obs(), O_IDLE); end
    n_checks++;
    if (cnts() !== exp_cnts(1, 0, 0)) begin n_fail++; $display("FAIL load_use_count got %h want %h", cnts(), exp_cnts(1, 0, 0)); end
    // match through rd_ID only
    @(negedge clock); set_hazard(3'd6); bus.useRs_ID = 0; bus.rs_ID = 3'd6; bus.rd_ID = 3'd6; #2;
    n_checks++;
    if (obs() !== O_LOAD) begin n_fail++; $display("FAIL load_use_rd got %b want %b", obs(), O_LOAD); end
    // not a register-writing load
    @(negedge clock); bus.regWrite_EX = 0; #2;
    n_checks++;
    if (obs() !== O_IDLE) begin n_fail++; $display("FAIL no_regwrite got %b want %b", obs(), O_IDLE); end
    @(negedge clock); bus.regWrite_EX = 1; bus.memRead_EX = 0; #2;
    n_checks++;
    if (obs() !== O_IDLE) begin n_fail++; $display("FAIL no_memread got %b want %b", obs(), O_IDLE); end
  endtask

  task automatic test_no_use();
    do_reset(); set_hazard(3'd3); bus.useRs_ID = 0; bus.rd_ID = 3'd3; bus.useRd_ID = 0; #2;
    n_checks++;
    if (obs() !== O_IDLE) begin n_fail++; $display("FAIL no_use got %b want %b", obs(), O_IDLE); end
    @(negedge clock); set_hazard(3'd3); bus.rs_ID = 3'd2; bus.rd_ID = 3'd1; #2;
    n_checks++;
    if (obs() !== O_IDLE) begin n_fail++; $display("FAIL no_match got %b want %b", obs(), O_IDLE); end
  endtask

  task automatic test_branch_priority();
    do_reset(); set_hazard(3'd3); bus.branchTaken_MEM = 1; #2;
    n_checks++;
    if (obs() !== O_BRANCH) begin n_fail++; $display("FAIL branch_over_stall got %b want %b", obs(), O_BRANCH); end
    @(negedge clock); set_idle(); #2;
    n_checks++;
    if (cnts() !== exp_cnts(0, 1, 0)) begin n_fail++; $display("FAIL branch_count got %h want %h", cnts(), exp_cnts(0, 1, 0)); end
  endtask

  task automatic test_mem_wait();
    do_reset(); bus.memAccess_MEM = 1; #2;
    n_checks++;
    if (obs() !== O_FROZEN) begin n_fail++; $display("FAIL wait_entry got %b want %b", obs(), O_FROZEN); end
    @(negedge clock); set_hazard(3'd2); bus.branchTaken_MEM = 1; #2;
    n_checks++;
    if (obs() !== O_FROZEN) begin n_fail++; $display("FAIL wait_ignores got %b want %b", obs(), O_FROZEN); end
    @(negedge clock); set_idle(); bus.memAccess_MEM = 1; #2;
    n_checks++;
    if (obs() !== O_IDLE) begin n_fail++; $display("FAIL wait_exit got %b want %b", obs(), O_IDLE); end
    @(negedge clock); set_idle(); #2;
    n_checks++;
    if (cnts() !== exp_cnts(0, 0, 2)) begin n_fail++; $display("FAIL wait_count got %h want %h", cnts(), exp_cnts(0, 0, 2)); end
    // branch held through the wait is acted on in the exit cycle
    bus.memAccess_MEM = 1; bus.branchTaken_MEM = 1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clock);
      #2;
      n_checks++;
      if (obs() !== O_FROZEN) begin n_fail++; $display("FAIL wait2_frozen%0d got %b want %b", i, obs(), O_FROZEN); end
    end
    @(negedge clock); #2;
    n_checks++;
    if (obs() !== O_BRANCH) begin n_fail++; $display("FAIL wait2_exit_branch got %b want %b", obs(), O_BRANCH); end
    @(negedge clock); set_idle(); #2;
    n_checks++;
    if (cnts() !== exp_cnts(0, 1, 4)) begin n_fail++; $display("FAIL wait2_count got %h want %h", cnts(), exp_cnts(0, 1, 4)); end
  endtask

  task automatic test_halt();
    do_reset(); bus.halt_WB = 1; #2;
    n_checks++;
    if (obs() !== O_IDLE) begin n_fail++; $display("FAIL halt_cycle got %b want %b", obs(), O_IDLE); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      set_hazard(3'($urandom_range(0, 7)));
      bus.memAccess_MEM = 1'($urandom_range(0, 1));
      bus.branchTaken_MEM = 1'($urandom_range(0, 1));
      bus.halt_WB = 0; #2;
      n_checks++;
      if (obs() !== O_HALTED) begin n_fail++; $display("FAIL halted_%0d got %b want %b", i, obs(), O_HALTED); end
    end
    @(negedge clock); reset = 1;
    @(negedge clock); reset = 0; set_idle(); #2;
    n_checks++;
    if (obs() !== O_IDLE) begin n_fail++; $display("FAIL halt_reset got %b want %b", obs(), O_IDLE); end
  endtask

  task automatic test_reset_in_wait();
    do_reset(); bus.memAccess_MEM = 1; #2;
    @(negedge clock); reset = 1; #2;
    n_checks++;
    if (obs() !== O_FROZEN) begin n_fail++; $display("FAIL rst_wait_mid got %b want %b", obs(), O_FROZEN); end
    @(negedge clock); reset = 0; set_idle(); #2;
    n_checks++;
    if (obs() !== O_IDLE) begin n_fail++; $display("FAIL rst_wait_run got %b want %b", obs(), O_IDLE); end
    n_checks++;
    if (cnts() !== 48'h0) begin n_fail++; $display("FAIL rst_wait_counters got %h want 0", cnts()); end
  endtask

  // Random traffic against a cycle-budget model of the controller
  task automatic test_random();
    bit         m_halt = 0;
    bit         m_exit = 0;    // next unfrozen cycle finishes a memory access
    int         m_left = 0;    // frozen wait cycles still to come
    int         halt_age = 0;
    int         ms = 0, mf = 0, mm = 0;
    logic [8:0] e;
    bit         hz;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      reset = (m_halt && halt_age > 3) || ($urandom_range(0, 299) == 0);
      bus.memRead_EX      = 1'($urandom_range(0, 1));
      bus.regWrite_EX     = ($urandom_range(0, 3) != 0);
      bus.rd_EX           = 3'($urandom_range(0, 7));
      bus.rs_ID           = $urandom_range(0, 1) ? bus.rd_EX : 3'($urandom_range(0, 7));
      bus.rd_ID           = $urandom_range(0, 1) ? bus.rd_EX : 3'($urandom_range(0, 7));
      bus.useRs_ID        = 1'($urandom_range(0, 1));
      bus.useRd_ID        = 1'($urandom_range(0, 1));
      bus.memAccess_MEM   = ($urandom_range(0, 4) == 0);
      bus.branchTaken_MEM = ($urandom_range(0, 5) == 0);
      bus.halt_WB         = ($urandom_range(0, 149) == 0);
      #2;
      n_checks++;
      if (cnts() !== exp_cnts(ms, mf, mm)) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL rand_counters cycle %0d got %h want %h", i, cnts(), exp_cnts(ms, mf, mm));
      end
      hz = bus.memRead_EX && bus.regWrite_EX &&
           ((bus.useRs_ID && bus.rs_ID == bus.rd_EX) || (bus.useRd_ID && bus.rd_ID == bus.rd_EX));
      if (m_halt) begin
        e = O_HALTED;
      end else if (m_left > 0) begin
        e = O_FROZEN; mm++; m_left--; m_exit = 1;
      end else if (bus.memAccess_MEM && LAT > 1 && !m_exit) begin
        e = O_FROZEN; mm++; m_left = LAT - 2; m_exit = 1;
      end else begin
        m_exit = 0;
        if (bus.branchTaken_MEM) begin e = O_BRANCH; mf++; end
        else if (hz)             begin e = O_LOAD;   ms++; end
        else                     e = O_IDLE;
      end
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL rand_outputs cycle %0d got %b want %b", i, obs(), e);
      end
      if (bus.halt_WB) begin m_halt = 1; m_left = 0; m_exit = 0; end
      halt_age = m_halt ? halt_age + 1 : 0;
      if (reset) begin
        m_halt = 0; m_left = 0; m_exit = 0; halt_age = 0; ms = 0; mf = 0; mm = 0;
      end
      if (ms > 65535) ms = 65535;
      if (mf > 65535) mf = 65535;
      if (mm > 65535) mm = 65535;
    end
    @(negedge clock); reset = 0; set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_no_use();
    test_branch_priority();
    test_mem_wait();
    test_halt();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipeline_stall_controller
`default_nettype wire
